pc_sequencer: RTL

- Instruction-cycle controller for the 8-bit processor.
- Sequences fetch/decode/execute phases and computes the next program-counter value.
- Drives the PC register's parallel load input and load strobe, the instruction-memory read strobe and the instruction-register load enable.
- Sits between the decoder/flags and the program counter; it is the only writer of the PC.

---
 rtl/pc_seq_pkg.sv | 16 +
 rtl/ret_addr_stack.sv | 49 ++++
 rtl/pc_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the instruction-cycle sequencer.
package pc_seq_pkg;

  localparam int AW_DEF       = 8;
  localparam int IMEM_LAT_MAX = 7;
  localparam int WAIT_CW      = $clog2(IMEM_LAT_MAX + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_WAIT   = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/ret_addr_stack.sv
// Return-address LIFO with full/empty flags and an overflow/underflow indicator.
module ret_addr_stack #(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic          clock_reg,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top_data,
  output logic          full,
  output logic          empty,
  output logic          ovf
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] cnt_q;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] top_idx;

  assign full     = (cnt_q == PW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign ovf      = (push && full) || (pop && empty);
  assign wr_idx   = IW'(cnt_q);
  assign top_idx  = IW'(cnt_q - PW'(1));
  assign top_data = empty ? '0 : mem[top_idx];

  always_ff @(posedge clock_reg) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (push && !full) begin
      cnt_q <= cnt_q + PW'(1);
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - PW'(1);
    end
  end

  // NOTE: storage is not reset; the occupancy count alone decides which entries are valid.
  always_ff @(posedge clock_reg) begin
    if (push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/wait/decode/execute controller and sole writer of the program counter.
// Optional return-address stack with op_call/op_ret/stk_err when CALL_STACK_EN is defined.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int AW          = AW_DEF,
  parameter int IMEM_LAT    = 1,
  parameter int STACK_DEPTH = 4
) (
  input  logic          clock_reg,
  input  logic          reset,
  input  logic [AW-1:0] pc_cur,
  input  logic          stall,
  input  logic          op_jump,
  input  logic          op_branch,
  input  logic          br_cond,
  input  logic          op_halt,
  input  logic [AW-1:0] target,
  input  logic          resume,
`ifdef CALL_STACK_EN
  input  logic          op_call,
  input  logic          op_ret,
  output logic          stk_err,
`endif
  output logic          imem_rd,
  output logic          ir_load,
  output logic          exec_en,
  output logic          pc_load,
  output logic [AW-1:0] pc_next,
  output logic          halted,
  output logic [2:0]    state_o
);

  localparam logic [WAIT_CW-1:0] LAT = WAIT_CW'(IMEM_LAT);

  if (IMEM_LAT < 0 || IMEM_LAT > IMEM_LAT_MAX || STACK_DEPTH < 1) begin : g_param_check
    $error("pc_sequencer: IMEM_LAT or STACK_DEPTH out of range");
  end

  seq_state_e         state_q, state_d;
  logic [WAIT_CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0]      pc_inc;
  logic [AW-1:0]      npc_d;
  logic               load_d;
  logic               exec_fire;

  assign pc_inc    = pc_cur + AW'(1);
  assign exec_fire = (state_q == S_EXEC) && !stall;
  assign halted    = (state_q == S_HALT);
  assign state_o   = state_q;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!stall) begin
      case (state_q)
        S_FETCH: begin
          cnt_d   = '0;
          state_d = (IMEM_LAT == 0) ? S_DECODE : S_WAIT;
        end
        S_WAIT: begin
          cnt_d = cnt_q + WAIT_CW'(1);
          if (cnt_q + WAIT_CW'(1) == LAT) state_d = S_DECODE;
        end
        S_DECODE: state_d = S_EXEC;
        S_EXEC:   state_d = op_halt ? S_HALT : S_FETCH;
        S_HALT:   if (resume) state_d = S_FETCH;
        default:  state_d = S_FETCH;
      endcase
    end
  end

`ifdef CALL_STACK_EN
  logic          stk_push, stk_pop, stk_full, stk_empty, stk_ovf;
  logic [AW-1:0] stk_top;

  ret_addr_stack #(
    .DEPTH (STACK_DEPTH),
    .AW    (AW)
  ) u_stack (
    .clock_reg (clock_reg),
    .reset     (reset),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_inc),
    .top_data  (stk_top),
    .full      (stk_full),
    .empty     (stk_empty),
    .ovf       (stk_ovf)
  );

  always_ff @(posedge clock_reg) begin
    if (reset) stk_err <= 1'b0;
    else       stk_err <= stk_err | stk_ovf;
  end
`endif

  // Next-PC selection; only takes effect when exec_fire registers it.
  always_comb begin
    npc_d  = pc_inc;
    load_d = 1'b1;
`ifdef CALL_STACK_EN
    stk_push = 1'b0;
    stk_pop  = 1'b0;
`endif
    if (op_halt) begin
      npc_d  = pc_cur;
      load_d = 1'b0;
    end
`ifdef CALL_STACK_EN
    else if (op_call) begin
      stk_push = exec_fire;
      if (!stk_full) npc_d = target;
    end else if (op_ret) begin
      stk_pop = exec_fire;
      if (!stk_empty) npc_d = stk_top;
    end
`endif
    else if (op_jump || (op_branch && br_cond)) begin
      npc_d = target;
    end
  end

  // Strobes are registered from the state being left, so a stalled edge yields a quiet cycle.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock_reg) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      imem_rd <= 1'b0;
      ir_load <= 1'b0;
      exec_en <= 1'b0;
      pc_load <= 1'b0;
      pc_next <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      imem_rd <= !stall && (state_q == S_FETCH);
      ir_load <= !stall && (state_q == S_DECODE);
      exec_en <= exec_fire;
      pc_load <= exec_fire && load_d;
      if (exec_fire) pc_next <= npc_d;
    end
  end

endmodule
